// File: rtl/shift_pkg.sv
// Shared definitions for the multi-step shift controller.
//   - Op-code constants for the single-step shifter.
//   - FSM state encoding of shift_sequencer.
//   - Default datapath width and shift-amount width.
package shift_pkg;

    localparam int DEF_W  = 16;
    localparam int DEF_AW = 4;

    localparam logic [1:0] SH_NONE  = 2'b00;
    localparam logic [1:0] SH_LEFT  = 2'b01;
    localparam logic [1:0] SH_RIGHT = 2'b10;
    localparam logic [1:0] SH_ASR   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shifter.sv
// Single-step combinational shifter.
//   in    : W-bit operand
//   shift : 00 pass, 01 left logical, 10 right logical, 11 right arithmetic
//   sout  : operand shifted by at most one position
module shifter
    import shift_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] in,
    input  logic [1:0]   shift,
    output logic [W-1:0] sout
);

    always_comb begin
        sout = in;
        case (shift)
            SH_LEFT:  sout = {in[W-2:0], 1'b0};
            SH_RIGHT: sout = {1'b0, in[W-1:1]};
            SH_ASR:   sout = {in[W-1], in[W-1:1]};
            default:  sout = in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Variable-amount shift controller built on the single-step shifter.
// A command (start in IDLE) latches din/op/amount; one shifter step is
// applied per clock on the accumulator, and done pulses for one cycle
// with dout valid.
//
// Handshake: start is a one-cycle request honoured only while busy=0;
// a request seen while busy=1 is dropped, never queued. done is a
// one-cycle completion pulse and dout holds until the next completion.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : command strobe (sampled in IDLE only)
//   din, op    : operand and shift type
//   amount     : number of positions to shift
//   dout       : result register
//   done       : one-cycle completion pulse
//   busy       : high whenever the FSM is not IDLE
//   state_dbg  : current FSM state, for observation
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  din,
    input  logic [1:0]    op,
    input  logic [AW-1:0] amount,
    output logic [W-1:0]  dout,
    output logic          done,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    state_e        state_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_d;
    logic [1:0]    op_q;
    logic [AW-1:0] cnt_q;
    logic [W-1:0]  dout_q;
    logic          done_q;

    shifter #(.W(W)) u_shifter (
        .in    (acc_q),
        .shift (op_q),
        .sout  (acc_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            op_q    <= SH_NONE;
            cnt_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q <= din;
                        op_q  <= op;
                        cnt_q <= amount;
                        // Nothing to shift: publish the operand directly.
                        if (amount == '0 || op == SH_NONE) begin
                            dout_q  <= din;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - AW'(1);
                    // Last step: take the shifter output straight into dout
                    // so the result is visible in the DONE cycle.
                    if (cnt_q == AW'(1)) begin
                        dout_q  <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout      = dout_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: table of directed vectors,
// hand-written blocking/reset sequences, and randomized commands checked
// against an arithmetic reference model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] din;
    logic [1:0]  op;
    logic [3:0]  amount;
    logic [15:0] dout;
    logic        done;
    logic        busy;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    shift_sequencer #(.W(16), .AW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .din       (din),
        .op        (op),
        .amount    (amount),
        .dout      (dout),
        .done      (done),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  o;
        logic [3:0]  a;
        logic [15:0] e;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: whole shift computed in one arithmetic step.
    function automatic logic [15:0] model_result(input logic [15:0] d,
                                                  input logic [1:0] o,
                                                  input logic [3:0] a);
        logic [15:0] r;
        case (o)
            2'b01:   r = d << a;
            2'b10:   r = d >> a;
            2'b11:   r = 16'($signed(d) >>> a);
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int model_latency(input logic [1:0] o, input logic [3:0] a);
        if (o == 2'b00 || a == 4'd0) return 1;
        return int'(a) + 1;
    endfunction

    // Issue one command from an IDLE cycle, follow it to completion and
    // check latency, busy, dout stability and the result. If block_at is
    // nonzero a stray start is pulsed in that cycle. Returns in the first
    // IDLE cycle after DONE.
    task automatic do_cmd(input logic [15:0] d, input logic [1:0] o,
                          input logic [3:0] a, input logic [15:0] exp_d,
                          input int exp_lat, input int block_at, input string nm);
        logic [15:0] prev;
        bit seen;
        prev = dout;
        start = 1'b1; din = d; op = o; amount = a;
        tick();
        start = 1'b0;
        din = 16'($urandom); op = 2'($urandom); amount = 4'($urandom);
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            check({nm, " busy"}, int'(busy), 1);
            if (done) begin
                seen = 1'b1;
                check({nm, " latency"}, c, exp_lat);
                check({nm, " dout"}, int'(dout), int'(exp_d));
            end else begin
                check({nm, " dout hold"}, int'(dout), int'(prev));
                if (c + 1 == block_at) begin
                    start = 1'b1; din = 16'h1234; op = 2'b01; amount = 4'd1;
                end else begin
                    start = 1'b0;
                end
                tick();
            end
        end
        start = 1'b0;
        if (!seen) check({nm, " done timeout"}, 0, 1);
        tick();
        check({nm, " idle busy"}, int'(busy), 0);
        check({nm, " idle done"}, int'(done), 0);
        check({nm, " idle dout"}, int'(dout), int'(exp_d));
    endtask

    initial begin
        logic [15:0] rd;
        logic [1:0]  ro;
        logic [3:0]  ra;

        vecs[0] = '{16'h0001, 2'b01, 4'd4,  16'h0010, 5};
        vecs[1] = '{16'h8000, 2'b11, 4'd3,  16'hF000, 4};
        vecs[2] = '{16'h8000, 2'b11, 4'd15, 16'hFFFF, 16};
        vecs[3] = '{16'h8000, 2'b10, 4'd15, 16'h0001, 16};
        vecs[4] = '{16'hABCD, 2'b01, 4'd0,  16'hABCD, 1};
        vecs[5] = '{16'h5A5A, 2'b00, 4'd7,  16'h5A5A, 1};
        vecs[6] = '{16'hFFFF, 2'b01, 4'd15, 16'h8000, 16};

        // Clock/reset.
        reset = 1'b1; start = 1'b0; din = '0; op = '0; amount = '0;
        tick(); tick();
        check("reset dout", int'(dout), 0);
        check("reset done", int'(done), 0);
        check("reset busy", int'(busy), 0);
        check("reset state", int'(state_dbg), 0);
        reset = 1'b0;
        tick();

        // Directed table, issued back to back.
        foreach (vecs[i])
            do_cmd(vecs[i].d, vecs[i].o, vecs[i].a, vecs[i].e, vecs[i].lat, 0,
                   $sformatf("vec%0d", i));

        // A start during busy is dropped.
        do_cmd(16'h00FF, 2'b01, 4'd8, 16'hFF00, 9, 3, "block");

        // Reset abort mid-shift.
        start = 1'b1; din = 16'h0003; op = 2'b01; amount = 4'd6;
        tick();
        start = 1'b0;
        check("abort c1 done", int'(done), 0);
        tick();
        check("abort c2 done", int'(done), 0);
        tick();
        reset = 1'b1;
        check("abort c3 done", int'(done), 0);
        tick();
        check("abort busy", int'(busy), 0);
        check("abort dout", int'(dout), 0);
        check("abort done", int'(done), 0);
        check("abort state", int'(state_dbg), 0);
        reset = 1'b0;
        tick();
        do_cmd(16'h0003, 2'b01, 4'd6, 16'h00C0, 7, 0, "after abort");

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; din = 16'h7777; op = 2'b10; amount = 4'd2;
        tick();
        reset = 1'b0; start = 1'b0;
        check("reset prio busy", int'(busy), 0);
        check("reset prio dout", int'(dout), 0);
        tick();
        check("reset prio still idle", int'(busy), 0);

        // Randomized commands against the model.
        for (int k = 0; k < 40; k++) begin
            rd = 16'($urandom);
            ro = 2'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 15));
            do_cmd(rd, ro, ra, model_result(rd, ro, ra), model_latency(ro, ra), 0,
                   $sformatf("rand%0d", k));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-step shift controller that drives the single-step 16-bit `shifter` datapath to perform shifts of 0–15 bit positions. It accepts a shift command and latches the operand. It then applies one `shifter` step per clock, feeding back the registered partial result, and reports completion with a one-cycle `done` pulse. It sits between the instruction decode/control FSM and the ALU operand path, replacing the fixed 1-bit shift with a variable-amount shift.

## Interface
Parameters:
- `W`, 16: datapath width; must match `shifter` width.
- `AW`, 4: shift-amount width; maximum amount is 2^AW−1.

Ports:
- `clk`  input  1  rising-edge clock, sole clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  command strobe; sampled only in IDLE.
- `din`  input  W  operand, latched when the command is accepted.
- `op`  input  2  shift type: 00 none, 01 left logical, 10 right logical, 11 right arithmetic (MSB replicated).
- `amount`  input  AW  number of bit positions to shift.
- `dout`  output  W  result register; holds its value until the next accepted command.
- `done`  output  1  one-cycle pulse; `dout` is valid in the same cycle.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE:**
  - If `start`=0, remain in IDLE.
  - If `start`=1, latch `din` into accumulator `acc`, latch `op` into `op_r`, and load `cnt`=`amount`.
  - If `amount`=0 or `op`=00, go to DONE and set `acc`=`din` unchanged.
  - Otherwise go to SHIFT.
- **SHIFT:**
  - Each cycle: `acc` ← `shifter(acc, op_r)` and `cnt` ← `cnt`−1.
  - When `cnt`=1 in the current cycle, go to DONE.
  - SHIFT therefore lasts exactly `amount` cycles.
- **DONE:**
  - `done`=1 and `dout`=`acc`.
  - Go unconditionally to IDLE.
- Shift arithmetic matches repeated `shifter` steps:
  - Left logical and right logical shifts fill with zeros.
  - Right arithmetic replicates bit W−1 at each step, so amount 15 yields all sign bits.
  - No wrap-around or rotation; bits shifted out are discarded.
- `dout` is updated only on entry to DONE; it is stable during SHIFT and IDLE.

## Timing
- Reset values: state=IDLE, `dout`=0, `done`=0, `busy`=0, `acc`=0, `cnt`=0.
- Latency is counted from the cycle `start` is sampled high in IDLE (cycle 0):
  - `done` rises in cycle `amount`+1 for a nonzero shift.
  - `done` rises in cycle 1 for a zero shift or op 00.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- `start` asserted while `busy`=1 (SHIFT or DONE) is ignored and not queued.
- Back-to-back commands: `start` may be asserted in the first IDLE cycle after DONE. The minimum command-to-command spacing is `amount`+2 cycles.
- `reset` asserted mid-operation aborts on the next edge:
  - All registers return to reset values.
  - No `done` pulse is emitted for the aborted command.
- `reset` has priority over `start` in the same cycle.
- `din`, `op` and `amount` need only be valid in the cycle `start` is accepted.

## Structure
- The shared package (`shift_pkg`) holds:
  - Op-code constants: `SH_NONE`=2'b00, `SH_LEFT`=2'b01, `SH_RIGHT`=2'b10, `SH_ASR`=2'b11.
  - State encodings for IDLE, SHIFT, DONE (2-bit).
  - Default widths W and AW.
- Sub-module: one instance of the existing `shifter`.
  - Its `in` is driven by `acc` and its `shift` by `op_r`; its `sout` feeds `acc`.
  - No other shifting logic is duplicated in this block.
- The FSM, counter and accumulator registers live in `shift_sequencer` itself.

## Test plan
- `din`=16'h0001, `op`=01, `amount`=4, `start` at cycle 0 → `done` at cycle 5, `dout`=16'h0010, `busy` high in cycles 1–5.
- `din`=16'h8000, `op`=11, `amount`=3 → `dout`=16'hF000 at cycle 4. Repeat with `amount`=15 → `dout`=16'hFFFF.
- `din`=16'h8000, `op`=10, `amount`=15 → `done` at cycle 16, `dout`=16'h0001.
- Zero-shift cases:
  - `din`=16'hABCD, `op`=01, `amount`=0 → `done` at cycle 1, `dout`=16'hABCD.
  - `op`=00, `amount`=7 → `done` at cycle 1, `dout`=`din`.
- Command blocking: start `din`=16'h00FF, `op`=01, `amount`=8, then pulse `start` with `din`=16'h1234 at cycle 3 → second command is ignored; `done` only at cycle 9 with `dout`=16'hFF00.
- Reset abort: command `amount`=6 with `reset` asserted at cycle 3 → from cycle 4 `busy`=0, `dout`=0, and no `done` pulse. A fresh command at cycle 5 completes normally.
